shift_rows_pipe: RTL

Parametrised, elastic ShiftRows/InvShiftRows unit for the AES/Rijndael datapath. It sits between SubBytes and MixColumns in both the encrypt and decrypt round pipelines. Each transaction selects its direction with a per-beat flag. A valid/ready register pipeline of configurable depth gives full throughput under backpressure, and a synchronous flush clears it.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/shift_rows_perm.sv | 22 ++
 rtl/shift_rows_pipe.sv | 82 ++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES state geometry helpers (legal column counts, ShiftRows offsets, byte indexing)
package aes_pkg;

  localparam int STAGES_MAX = 4;

  function automatic logic nb_legal(input int nb);
    return nb == 4 || nb == 6 || nb == 8;
  endfunction

  // Rijndael with 256-bit blocks shifts rows 2 and 3 by one extra column
  function automatic int row_off(input int nb, input int r);
    return (nb == 8 && r >= 2) ? r + 1 : r;
  endfunction

  function automatic int byte_idx(input int r, input int c);
    return 4 * c + r;
  endfunction

  function automatic int state_w(input int nb);
    return 32 * nb;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// shift_rows_perm: combinational ShiftRows/InvShiftRows byte permutation; byte 0 sits at the MSB end
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4,
  localparam int W = state_w(NB)
) (
  input  logic         inv_i,
  input  logic [W-1:0] state_i,
  output logic [W-1:0] state_o
);

  for (genvar r = 0; r < 4; r++) begin : g_r
    for (genvar c = 0; c < NB; c++) begin : g_c
      localparam int F = byte_idx(r, (c + row_off(NB, r)) % NB);
      localparam int I = byte_idx(r, (c - row_off(NB, r) + NB) % NB);
      localparam int O = byte_idx(r, c);
      assign state_o[W-1-8*O -: 8] = inv_i ? state_i[W-1-8*I -: 8] : state_i[W-1-8*F -: 8];
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: elastic ShiftRows/InvShiftRows unit followed by a STAGES-deep valid/ready slot pipeline
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB = 4,
  parameter int STAGES = 1,
  localparam int W = state_w(NB)
) (
  input  logic         clk,
  input  logic         asy_reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [W-1:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_inv,
  output logic [W-1:0] out_state,
  output logic         busy
);

  logic [W-1:0]      perm;
  logic [STAGES-1:0] ld, vld_d, vld_q, inv_d, inv_q;
  logic [W-1:0]      dat_d [STAGES];
  logic [W-1:0]      dat_q [STAGES];

  if (!nb_legal(NB) || STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad
    $error("shift_rows_pipe: illegal NB=%0d or STAGES=%0d", NB, STAGES);
  end

  shift_rows_perm #(.NB(NB)) u_perm (
    .inv_i  (in_inv),
    .state_i(in_state),
    .state_o(perm)
  );

  // a slot may load when it is empty or its contents move on this same edge
  always_comb begin
    ld[STAGES-1] = !vld_q[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) ld[k] = !vld_q[k] || ld[k+1];
  end

  assign in_ready = asy_reset && !flush && ld[0];

  always_comb begin
    vld_d = vld_q;
    inv_d = inv_q;
    dat_d = dat_q;
    if (ld[0]) vld_d[0] = in_valid && in_ready;
    if (ld[0] && in_valid && in_ready) begin
      inv_d[0] = in_inv;
      dat_d[0] = perm;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (ld[k]) vld_d[k] = vld_q[k-1];
      if (ld[k] && vld_q[k-1]) begin
        inv_d[k] = inv_q[k-1];
        dat_d[k] = dat_q[k-1];
      end
    end
    if (flush) vld_d = '0;
  end

  always_ff @(posedge clk or negedge asy_reset) begin
    if (!asy_reset) begin
      vld_q <= '0;
      inv_q <= '0;
      dat_q <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      inv_q <= inv_d;
      dat_q <= dat_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_inv   = inv_q[STAGES-1];
  assign out_state = dat_q[STAGES-1];
  assign busy      = |vld_q;

endmodule
